alt_slot_scheduler: RTL

ALT_SLOT_SCHEDULER -- requirements
Module: alt_slot_scheduler

---
 rtl/alt_slot_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alt_slot_scheduler.sv
// Alternating home/rotating slot scheduler: bit0 is interleaved with a round-robin over bits 7:1.
// Optional forced release after 16 held cycles is compiled in with `define SCHED_TIMEOUT_EN.
module alt_slot_scheduler (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       home_slot,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic PH_HOME = 1'b0;
  localparam logic PH_ROT  = 1'b1;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic       phase_q, phase_d;
  logic [2:0] ptr_q, ptr_d;
  logic       rot_hit;
  logic [2:0] rot_idx;
  logic [3:0] cand;

`ifdef SCHED_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
`endif

  // Cyclic search over 1..7 starting just after the last rotating index served.
  always_comb begin
    rot_hit = 1'b0;
    rot_idx = ptr_q;
    cand    = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand > 4'd7) cand = cand - 4'd7;
      if (!rot_hit && req[cand[2:0]]) begin
        rot_hit = 1'b1;
        rot_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef SCHED_TIMEOUT_EN
        cnt_d = 4'd0;
`endif
        if (phase_q == PH_HOME && req[0]) begin
          gnt_d   = 8'h01;
          phase_d = PH_ROT;
          state_d = HOLD;
        end else if (rot_hit) begin
          gnt_d   = 8'h01 << rot_idx;
          phase_d = PH_HOME;
          ptr_d   = rot_idx;
          state_d = HOLD;
        end else if (req[0]) begin
          gnt_d   = 8'h01;
          phase_d = PH_ROT;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // done takes priority over an expiry landing on the same edge
        if (done) begin
          gnt_d   = 8'h00;
          state_d = IDLE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == 4'hF) begin
          gnt_d   = 8'h00;
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      phase_q <= PH_HOME;
      ptr_q   <= 3'd7;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= 4'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == HOLD);
  assign home_slot = (gnt_q == 8'h01);
`ifdef SCHED_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
